hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core. It generates the `clearcontrol` bubble request consumed by the ID-stage control decoder.
- Also drives PC/IF-ID write enables and the flush strobes.
- Sequences multi-cycle data-memory stalls using a ready handshake with a timeout FSM.
- Resolves priority between memory freeze, EX-stage redirect (branch/jal/jalr) and load-use interlock.

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
// master = pipeline (drives hazard inputs), slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic       idex_memread;
  logic [4:0] idex_rd;
  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic       ifid_use_rs1;
  logic       ifid_use_rs2;
  logic       ex_pcsrc;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pcwrite;
  logic       ifid_write;
  logic       ifid_flush;
  logic       clearcontrol;
  logic       freeze;
  logic       mem_err;

  modport master (
    output idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
    output ex_pcsrc, dmem_req, dmem_ready,
    input  pcwrite, ifid_write, ifid_flush, clearcontrol, freeze, mem_err
  );

  modport slave (
    input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
    input  ex_pcsrc, dmem_req, dmem_ready,
    output pcwrite, ifid_write, ifid_flush, clearcontrol, freeze, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: memory freeze, redirect flush, load-use bubble
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_mem_stalls,
`endif
  hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             mem_err_q, mem_err_nxt;
  logic             memstall, loaduse, frz, rule_flush, rule_lu;

  // A ready cycle in WAIT is not a stall: the access completes and the pipe moves.
  always_comb begin
    memstall   = ((state == WAIT) & ~hif.dmem_ready) |
                 ((state == RUN) & hif.dmem_req & ~hif.dmem_ready);
    loaduse    = hif.idex_memread & (|hif.idex_rd) &
                 ((hif.ifid_use_rs1 & (hif.ifid_rs1 == hif.idex_rd)) |
                  (hif.ifid_use_rs2 & (hif.ifid_rs2 == hif.idex_rd)));
    frz        = (state == ERR) | memstall;
    rule_flush = ~frz & hif.ex_pcsrc;
    rule_lu    = ~frz & ~hif.ex_pcsrc & loaduse;
  end

  assign hif.freeze       = frz;
  assign hif.pcwrite      = ~frz & ~rule_lu;
  assign hif.ifid_write   = ~frz & ~rule_lu;
  assign hif.ifid_flush   = rule_flush;
  assign hif.clearcontrol = rule_flush | rule_lu;
  assign hif.mem_err      = mem_err_q;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err_q;
    case (state)
      RUN: begin
        if (hif.dmem_req & ~hif.dmem_ready) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end
      end
      WAIT: begin
        if (hif.dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_C) begin
          state_nxt   = ERR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ERR: begin
        mem_err_nxt = 1'b1;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_stalls  <= '0;
      perf_flushes    <= '0;
      perf_mem_stalls <= '0;
    end else begin
      if (rule_lu)    perf_lu_stalls  <= perf_lu_stalls + 32'd1;
      if (rule_flush) perf_flushes    <= perf_flushes + 32'd1;
      if (frz)        perf_mem_stalls <= perf_mem_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

  // Output vector order: {pcwrite, ifid_write, ifid_flush, clearcontrol, freeze, mem_err}
  localparam logic [5:0] IDLE = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] FLSH = 6'b111100;
  localparam logic [5:0] FRZ  = 6'b000010;
  localparam logic [5:0] ERRV = 6'b000011;

  typedef struct packed {
    logic       pc;
    logic       rq;
    logic       rdy;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u1;
    logic       u2;
    logic [5:0] want;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_flushes, perf_mem_stalls;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(10)) dut (
    .clk(clk),
    .rst(rst),
`ifdef HAZARD_PERF_CNT_EN
    .perf_lu_stalls(perf_lu_stalls),
    .perf_flushes(perf_flushes),
    .perf_mem_stalls(perf_mem_stalls),
`endif
    .hif(hif)
  );

  function automatic logic [5:0] outs();
    return {hif.pcwrite, hif.ifid_write, hif.ifid_flush, hif.clearcontrol, hif.freeze, hif.mem_err};
  endfunction

  task automatic apply(input row_t r);
    @(posedge clk);
    #1;
    hif.ex_pcsrc     = r.pc;
    hif.dmem_req     = r.rq;
    hif.dmem_ready   = r.rdy;
    hif.idex_memread = r.mr;
    hif.idex_rd      = r.rd;
    hif.ifid_rs1     = r.r1;
    hif.ifid_rs2     = r.r2;
    hif.ifid_use_rs1 = r.u1;
    hif.ifid_use_rs2 = r.u2;
    sb.push_back(r.want);
  endtask

  task automatic test_reset();
    logic [5:0] want;
    apply('{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,IDLE});
    @(negedge clk);
    want = sb.pop_front();
    total++;
    if (outs() !== want) begin
      bad++;
      $display("FAIL reset_outputs: got=%b want=%b", outs(), want);
    end
    total++;
    if (dut.wait_cnt !== 10'd0) begin
      bad++;
      $display("FAIL reset_wait_cnt: got=%0d want=0", dut.wait_cnt);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_load_use();
    row_t t[3];
    logic [5:0] want;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,5'd5,5'd0,5'd5,1'b0,1'b1,LU};
    t[1] = '{1'b0,1'b0,1'b0,1'b0,5'd5,5'd0,5'd5,1'b0,1'b1,IDLE};
    t[2] = '{1'b0,1'b0,1'b0,1'b1,5'd17,5'd17,5'd2,1'b1,1'b1,LU};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = sb.pop_front();
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL load_use step%0d: got=%b want=%b", i, outs(), want);
      end
    end
  endtask

  task automatic test_x0_unused();
    row_t t[3];
    logic [5:0] want;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,5'd0,5'd0,5'd0,1'b1,1'b1,IDLE};
    t[1] = '{1'b0,1'b0,1'b0,1'b1,5'd9,5'd9,5'd3,1'b0,1'b1,IDLE};
    t[2] = '{1'b0,1'b0,1'b0,1'b1,5'd9,5'd9,5'd3,1'b1,1'b0,LU};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = sb.pop_front();
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL x0_unused step%0d: got=%b want=%b", i, outs(), want);
      end
    end
  endtask

  task automatic test_redirect();
    row_t t[3];
    logic [5:0] want;
    t[0] = '{1'b1,1'b0,1'b0,1'b1,5'd7,5'd1,5'd7,1'b1,1'b1,FLSH};
    t[1] = '{1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FLSH};
    t[2] = '{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,IDLE};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = sb.pop_front();
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL redirect step%0d: got=%b want=%b", i, outs(), want);
      end
    end
  endtask

  task automatic test_mem_wait();
    row_t t[7];
    logic [5:0] want;
    t[0] = '{1'b1,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FRZ};
    t[1] = '{1'b1,1'b0,1'b0,1'b1,5'd5,5'd5,5'd0,1'b1,1'b0,FRZ};
    t[2] = '{1'b1,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FRZ};
    t[3] = '{1'b1,1'b1,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FLSH};
    t[4] = '{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,IDLE};
    t[5] = '{1'b0,1'b1,1'b1,1'b1,5'd4,5'd4,5'd0,1'b1,1'b0,LU};
    t[6] = '{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,IDLE};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = sb.pop_front();
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL mem_wait step%0d: got=%b want=%b", i, outs(), want);
      end
      if (i == 4) begin
        total++;
        if (dut.wait_cnt !== 10'd0 || dut.state !== 2'd0) begin
          bad++;
          $display("FAIL mem_wait_return: got cnt=%0d state=%0d want cnt=0 state=0", dut.wait_cnt, dut.state);
        end
      end
    end
  endtask

  task automatic test_timeout();
    row_t t[8];
    logic [5:0] want;
    for (int i = 0; i < 5; i++)
      t[i] = '{1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FRZ};
    t[5] = '{1'b0,1'b1,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,ERRV};
    t[6] = '{1'b1,1'b0,1'b0,1'b1,5'd3,5'd3,5'd0,1'b1,1'b0,ERRV};
    t[7] = '{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,ERRV};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = sb.pop_front();
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL timeout step%0d: got=%b want=%b", i, outs(), want);
      end
    end
    // Asynchronous clear between clock edges.
    #1 rst = 1'b0;
    sb.push_back(IDLE);
    #1;
    want = sb.pop_front();
    total++;
    if (outs() !== want) begin
      bad++;
      $display("FAIL async_reset_clear: got=%b want=%b", outs(), want);
    end
    #1 rst = 1'b1;
    apply('{1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,IDLE});
    @(negedge clk);
    want = sb.pop_front();
    total++;
    if (outs() !== want) begin
      bad++;
      $display("FAIL post_reset_idle: got=%b want=%b", outs(), want);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    row_t t[7];
    logic [5:0] want;
    @(negedge clk);
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,5'd5,5'd0,5'd5,1'b0,1'b1,LU};
    t[1] = '{1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FLSH};
    t[2] = '{1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FLSH};
    t[3] = '{1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FRZ};
    t[4] = '{1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FRZ};
    t[5] = '{1'b0,1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,FRZ};
    t[6] = '{1'b0,1'b1,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,IDLE};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      want = sb.pop_front();
      total++;
      if (outs() !== want) begin
        bad++;
        $display("FAIL perf_run step%0d: got=%b want=%b", i, outs(), want);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (perf_lu_stalls !== 32'd1 || perf_flushes !== 32'd2 || perf_mem_stalls !== 32'd3) begin
      bad++;
      $display("FAIL perf_counts: got lu=%0d fl=%0d mem=%0d want lu=1 fl=2 mem=3",
               perf_lu_stalls, perf_flushes, perf_mem_stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_redirect();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
